// File: rtl/heap_level_stage.sv
// Sift-down stage for one level of a pipelined min-heap. It compares a replace
// token with the two children of its hole, writes the smaller value back upstream
// and, when the token moves down, hands it to the next stage.
module heap_level_stage #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 5,
  parameter int LEVEL        = 1,
  parameter int HAS_CHILDREN = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic [ADDR_WIDTH-1:0] in_hole,
  output logic                  wb_up_valid,
  output logic [ADDR_WIDTH-1:0] wb_up_addr,
  output logic [DATA_WIDTH-1:0] wb_up_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [ADDR_WIDTH-1:0] out_hole,
  input  logic                  wb_dn_valid,
  input  logic [ADDR_WIDTH-1:0] wb_dn_addr,
  input  logic [DATA_WIDTH-1:0] wb_dn_data,
  output logic [ADDR_WIDTH-1:0] ram_addr_a,
  output logic [ADDR_WIDTH-1:0] ram_addr_b,
  output logic [DATA_WIDTH-1:0] ram_data_a,
  output logic                  ram_we_a,
  input  logic [DATA_WIDTH-1:0] ram_q_a,
  input  logic [DATA_WIDTH-1:0] ram_q_b,
  output logic                  err
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    READ    = 3'd1,
    COMMIT  = 3'd2,
    FWD     = 3'd3,
    WAIT_WB = 3'd4
  } state_t;

  // A level holds 1<<LEVEL entries, so child indices never exceed LEVEL bits.
  localparam logic [ADDR_WIDTH-1:0] LEVEL_MASK = ADDR_WIDTH'((1 << LEVEL) - 1);

  state_t                  state_r, state_s;
  logic [DATA_WIDTH-1:0]   v_r, c_r, min_s;
  logic [ADDR_WIDTH-1:0]   q_r, ci_r, child_a_s, child_b_s;
  logic                    stop_r, stop_s, sel_b_s, run_r, err_r;

  assign err = err_r;

  // Child selection: the right child wins only when strictly smaller.
  always_comb begin
    child_a_s = {q_r[ADDR_WIDTH-2:0], 1'b0} & LEVEL_MASK;
    child_b_s = {q_r[ADDR_WIDTH-2:0], 1'b1} & LEVEL_MASK;
    sel_b_s   = (ram_q_b < ram_q_a);
    min_s     = sel_b_s ? ram_q_b : ram_q_a;
    if (HAS_CHILDREN == 0) begin
      stop_s = 1'b1;
    end else begin
      stop_s = (v_r <= min_s);
    end
  end

  // Next-state and output decode.
  always_comb begin
    state_s     = state_r;
    in_ready    = 1'b0;
    wb_up_valid = 1'b0;
    wb_up_addr  = {ADDR_WIDTH{1'b0}};
    wb_up_data  = {DATA_WIDTH{1'b0}};
    out_valid   = 1'b0;
    out_data    = {DATA_WIDTH{1'b0}};
    out_hole    = {ADDR_WIDTH{1'b0}};
    ram_addr_a  = {ADDR_WIDTH{1'b0}};
    ram_addr_b  = {ADDR_WIDTH{1'b0}};
    ram_data_a  = {DATA_WIDTH{1'b0}};
    ram_we_a    = 1'b0;
    case (state_r)
      IDLE: begin
        in_ready = run_r;
        if (in_valid && run_r) begin
          state_s = READ;
        end else begin
          state_s = IDLE;
        end
      end
      READ: begin
        if (HAS_CHILDREN != 0) begin
          ram_addr_a = child_a_s;
          ram_addr_b = child_b_s;
        end else begin
          ram_addr_a = {ADDR_WIDTH{1'b0}};
          ram_addr_b = {ADDR_WIDTH{1'b0}};
        end
        state_s = COMMIT;
      end
      COMMIT: begin
        wb_up_valid = 1'b1;
        wb_up_addr  = q_r;
        wb_up_data  = stop_r ? v_r : c_r;
        state_s     = stop_r ? IDLE : FWD;
      end
      FWD: begin
        out_valid = 1'b1;
        out_data  = v_r;
        out_hole  = ci_r;
        state_s   = out_ready ? WAIT_WB : FWD;
      end
      WAIT_WB: begin
        // Stay closed until the child's hole write has landed in this level.
        if (wb_dn_valid) begin
          ram_we_a   = 1'b1;
          ram_addr_a = wb_dn_addr;
          ram_data_a = wb_dn_data;
          state_s    = IDLE;
        end else begin
          state_s = WAIT_WB;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Token capture in IDLE and compare result capture in READ.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_r    <= {DATA_WIDTH{1'b0}};
      q_r    <= {ADDR_WIDTH{1'b0}};
      c_r    <= {DATA_WIDTH{1'b0}};
      ci_r   <= {ADDR_WIDTH{1'b0}};
      stop_r <= 1'b0;
    end else begin
      if (state_r == IDLE && in_valid && run_r) begin
        v_r <= in_data;
        q_r <= in_hole;
      end
      if (state_r == READ) begin
        stop_r <= stop_s;
        c_r    <= min_s;
        ci_r   <= sel_b_s ? child_b_s : child_a_s;
      end
    end
  end

  // Ready gating out of reset and the sticky protocol-error flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_r <= 1'b0;
      err_r <= 1'b0;
    end else begin
      run_r <= 1'b1;
      if (wb_dn_valid && state_r != WAIT_WB) begin
        err_r <= 1'b1;
      end
    end
  end

endmodule

// File: doc/heap_level_stage.md
Name: heap_level_stage

Overview:
- Per-level sift-down controller for the pipelined min-heap used by heap-sort / top-K feature selection.
- Stage LEVEL owns the two ports of its level's dual-port RAM (LEVEL-sized, 1<<LEVEL entries, asynchronous read, synchronous write).
- Receives a replace token (value plus hole position in level LEVEL-1) from the stage above.
- Compares the token value against the hole's two children in its own level. It writes the winner back into the hole upstream and, on a swap, forwards the token to stage LEVEL+1.

Parameters:
- DATA_WIDTH, 32, key width (unsigned compare).
- ADDR_WIDTH, 5, RAM address width; must be >= LEVEL.
- LEVEL, 1, heap level owned by this stage (>=1).
- HAS_CHILDREN, 1, 0 = level LEVEL does not exist (leaf terminator); no RAM reads, token always stops.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  token from stage LEVEL-1
- in_ready  out  1  stage can accept token
- in_data  in  DATA_WIDTH  token value v
- in_hole  in  ADDR_WIDTH  hole index q in level LEVEL-1
- wb_up_valid  out  1  write request into level LEVEL-1 RAM (no ready; upstream always accepts)
- wb_up_addr  out  ADDR_WIDTH  = q
- wb_up_data  out  DATA_WIDTH  value written into hole
- out_valid  out  1  token to stage LEVEL+1
- out_ready  in  1  downstream accepts
- out_data  out  DATA_WIDTH  forwarded v
- out_hole  out  ADDR_WIDTH  new hole index in level LEVEL
- wb_dn_valid  in  1  write request from stage LEVEL+1 into this level
- wb_dn_addr  in  ADDR_WIDTH  write address
- wb_dn_data  in  DATA_WIDTH  write data
- ram_addr_a  out  ADDR_WIDTH  RAM port A address
- ram_addr_b  out  ADDR_WIDTH  RAM port B address
- ram_data_a  out  DATA_WIDTH  RAM port A write data
- ram_we_a  out  1  RAM port A write enable (port B never writes)
- ram_q_a  in  DATA_WIDTH  RAM port A read data
- ram_q_b  in  DATA_WIDTH  RAM port B read data
- err  out  1  sticky protocol-error flag

Behaviour:
- Reset (async, rst_n low):
  - state=IDLE; all outputs 0 except in_ready (0 during reset, 1 in IDLE after release); err=0.
  - RAM contents not reset.
  - Token in flight is dropped; all stages reset together.
- FSM states: IDLE, READ, COMMIT, FWD, WAIT_WB.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: latch v, q; go to READ.
- READ (1 cycle):
  - ram_addr_a={q[ADDR_WIDTH-2:0],0}; ram_addr_b={q[ADDR_WIDTH-2:0],1}.
  - c = min(ram_q_a, ram_q_b); tie selects port A (left child).
  - stop = (v <= c), or HAS_CHILDREN=0.
  - Register stop, c and child index ci.
  - Go to COMMIT.
- COMMIT (1 cycle):
  - wb_up_valid=1, wb_up_addr=q, wb_up_data = stop ? v : c.
  - If stop, go to IDLE; else go to FWD.
- FWD:
  - out_valid=1, out_data=v, out_hole=ci; values held stable until out_ready.
  - On out_valid&&out_ready: go to WAIT_WB.
- WAIT_WB:
  - in_ready=0 (interlock: the downstream hole write must land before this level is read again).
  - On wb_dn_valid: ram_we_a=1, ram_addr_a=wb_dn_addr, ram_data_a=wb_dn_data; go to IDLE.
- Port usage outside the above: in every other state ram_we_a=0 and addresses are don't-care (drive 0).
- Latency (token accepted at edge 0):
  - READ in cycle 1; wb_up_valid in cycle 2.
  - out_valid earliest cycle 3.
  - Stop path: in_ready high again in cycle 3.
- Timing rules:
  - wb_up_valid is exactly one cycle per token, never repeated under backpressure.
  - Minimum initiation interval on a swap path: 3 cycles + downstream round trip.
- Protocol error: wb_dn_valid outside WAIT_WB is ignored (no RAM write) and sets err=1, which stays set until reset.

Test Plan:
- Leaf (HAS_CHILDREN=0): in v=7, q=3 accepted cycle 0 -> wb_up_valid cycle 2 with addr=3, data=7; out_valid never asserted; in_ready=1 cycle 3.
- Stop (LEVEL=2): RAM[2]=10, RAM[3]=12; v=5, q=1 -> ram_addr_a=2, ram_addr_b=3 in READ; wb_up addr=1, data=5; no forward.
- Equal-to-min stop: RAM[2]=5, RAM[3]=9; v=5, q=1 -> wb_up data=5, no forward.
- Swap with child tie: RAM[2]=4, RAM[3]=4; v=9, q=1 -> wb_up addr=1, data=4; out_data=9, out_hole=2; in_ready=0 until wb_dn addr=2, data=9 -> RAM[2]=9, state IDLE.
- Backpressure: swap case with out_ready=0 for 5 cycles -> out_valid/data/hole stable throughout; wb_up_valid pulsed exactly once; in_valid held high meanwhile is not accepted.
- Error/reset: wb_dn_valid in IDLE -> no ram_we_a, err=1 and stays 1. Separately, rst_n low during FWD -> out_valid=0 immediately (async), IDLE after release, RAM unchanged.
